// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scancode decoder: folds E0/F0 prefixes into key events and queues them in a show-ahead FIFO.
// It also tracks held levels for the four arrow keys and space.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  input  logic       event_ready,
  input  logic       overflow_clr,
  output logic       event_valid,
  output logic [7:0] event_code,
  output logic       event_extended,
  output logic       event_release,
  output logic       key_left,
  output logic       key_right,
  output logic       key_up,
  output logic       key_down,
  output logic       key_space,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            left_q, right_q, up_q, down_q, space_q, overflow_q;
  logic [AW:0]     wr_q, rd_q;
  logic [9:0]      mem_q [FIFO_DEPTH];

  logic            is_e0, is_f0, is_ctrl;
  logic            emit, ev_ext, ev_rel;
  logic            empty, full, pop, push;

  always_comb begin
    is_e0   = (received_data == 8'hE0);
    is_f0   = (received_data == 8'hF0);
    is_ctrl = 1'b0;
    case (received_data)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_ctrl = 1'b1;
      default: is_ctrl = 1'b0;
    endcase
    ev_ext = (state_q == S_EXT) || (state_q == S_EXT_BRK);
    ev_rel = (state_q == S_BRK) || (state_q == S_EXT_BRK);
    // Device-control bytes are only filtered outside a sequence; after a prefix they are real codes.
    emit   = received_data_en && !is_e0 && !is_f0 && !(state_q == S_IDLE && is_ctrl);
  end

  always_comb begin
    empty = (wr_q == rd_q);
    full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop   = !empty && event_ready;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    push  = emit && (!full || pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else if (received_data_en) begin
      cnt_q <= '0;
      if (is_e0) begin
        state_q <= S_EXT;
      end else if (is_f0) begin
        case (state_q)
          S_IDLE:  state_q <= S_BRK;
          S_EXT:   state_q <= S_EXT_BRK;
          default: state_q <= state_q;
        endcase
      end else begin
        state_q <= S_IDLE;
      end
    end else if (state_q != S_IDLE) begin
      if (cnt_q == CNT_LAST) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left_q  <= 1'b0;
      right_q <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      space_q <= 1'b0;
    end else if (emit) begin
      if (ev_ext) begin
        case (received_data)
          8'h6B:   left_q  <= !ev_rel;
          8'h74:   right_q <= !ev_rel;
          8'h75:   up_q    <= !ev_rel;
          8'h72:   down_q  <= !ev_rel;
          default: ;
        endcase
      end else if (received_data == 8'h29) begin
        space_q <= !ev_rel;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q       <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop)  rd_q <= rd_q + (AW+1)'(1);
      if (emit && !push)     overflow_q <= 1'b1;
      else if (overflow_clr) overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {ev_ext, ev_rel, received_data};
  end

  assign event_valid    = !empty;
  assign event_code     = mem_q[rd_q[AW-1:0]][7:0];
  assign event_release  = mem_q[rd_q[AW-1:0]][8];
  assign event_extended = mem_q[rd_q[AW-1:0]][9];
  assign key_left       = left_q;
  assign key_right      = right_q;
  assign key_up         = up_q;
  assign key_down       = down_q;
  assign key_space      = space_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder with FIFO_DEPTH=4 and a 16-cycle prefix timeout.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic       event_ready = 1'b0;
  logic       overflow_clr = 1'b0;
  logic       event_valid, event_extended, event_release;
  logic [7:0] event_code;
  logic       key_left, key_right, key_up, key_down, key_space, overflow;

  int n_cmp = 0;
  int n_err = 0;

  ps2_scancode_decoder #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .received_data(received_data), .received_data_en(received_data_en),
    .event_ready(event_ready), .overflow_clr(overflow_clr),
    .event_valid(event_valid), .event_code(event_code),
    .event_extended(event_extended), .event_release(event_release),
    .key_left(key_left), .key_right(key_right), .key_up(key_up),
    .key_down(key_down), .key_space(key_space), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; returns on the negedge after the accepting posedge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    received_data    = b;
    received_data_en = 1'b1;
    @(negedge clk);
    received_data_en = 1'b0;
    $display("byte %02h sent", b);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] code, input logic ext, input logic rel);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(event_valid), 32'd1);
    chk({tag, "_entry"}, {22'd0, event_extended, event_release, event_code}, {22'd0, ext, rel, code});
    event_ready = 1'b1;
    @(negedge clk);
    event_ready = 1'b0;
    $display("pop %s code=%02h ext=%0d rel=%0d", tag, event_code, event_extended, event_release);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(event_valid), 32'd0);
    chk("rst_keys", {26'd0, key_left, key_right, key_up, key_down, key_space, overflow}, 32'd0);
    reset_n = 1'b1;

    // Make/break of a plain key
    send(8'h1C);
    chk("valid_after_first", 32'(event_valid), 32'd1);
    send(8'hF0);
    send(8'h1C);
    pop_chk("1c_make", 8'h1C, 1'b0, 1'b0);
    pop_chk("1c_break", 8'h1C, 1'b0, 1'b1);
    @(negedge clk);
    chk("empty_after_1c", 32'(event_valid), 32'd0);

    // Extended left arrow held then released
    send(8'hE0);
    send(8'h6B);
    chk("left_set", 32'(key_left), 32'd1);
    send(8'hE0);
    send(8'hF0);
    chk("left_still", 32'(key_left), 32'd1);
    send(8'h6B);
    chk("left_clr", 32'(key_left), 32'd0);
    pop_chk("6b_make", 8'h6B, 1'b1, 1'b0);
    pop_chk("6b_break", 8'h6B, 1'b1, 1'b1);

    // Fill and overflow
    send(8'h15);
    send(8'h1D);
    send(8'h24);
    send(8'h2D);
    chk("ovf_before", 32'(overflow), 32'd0);
    send(8'h35);
    chk("ovf_set", 32'(overflow), 32'd1);
    // Simultaneous push and pop while full
    @(negedge clk);
    chk("head_15", 32'(event_code), 32'h15);
    event_ready      = 1'b1;
    received_data    = 8'h3C;
    received_data_en = 1'b1;
    @(negedge clk);
    event_ready      = 1'b0;
    received_data_en = 1'b0;
    $display("push 3c with pop while full");
    chk("ovf_kept", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    pop_chk("f_1d", 8'h1D, 1'b0, 1'b0);
    pop_chk("f_24", 8'h24, 1'b0, 1'b0);
    pop_chk("f_2d", 8'h2D, 1'b0, 1'b0);
    pop_chk("f_3c", 8'h3C, 1'b0, 1'b0);
    @(negedge clk);
    chk("empty_after_fill", 32'(event_valid), 32'd0);

    // Prefix abandoned after timeout
    send(8'hE0);
    repeat (20) @(negedge clk);
    send(8'h6B);
    chk("to_left", 32'(key_left), 32'd0);
    pop_chk("to_6b", 8'h6B, 1'b0, 1'b0);

    // Short gap keeps the prefix
    send(8'hE0);
    repeat (8) @(negedge clk);
    send(8'h75);
    chk("up_set", 32'(key_up), 32'd1);
    pop_chk("short_75", 8'h75, 1'b1, 1'b0);

    // Control bytes
    send(8'hAA);
    send(8'hFA);
    @(negedge clk);
    chk("ctrl_ignored", 32'(event_valid), 32'd0);
    send(8'hF0);
    send(8'hFA);
    pop_chk("brk_fa", 8'hFA, 1'b0, 1'b1);

    // Reset mid-sequence
    send(8'h29);
    chk("space_set", 32'(key_space), 32'd1);
    send(8'hE0);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst2_space", 32'(key_space), 32'd0);
    chk("rst2_valid", 32'(event_valid), 32'd0);
    chk("rst2_up", 32'(key_up), 32'd0);
    reset_n = 1'b1;
    send(8'h74);
    chk("right_unchanged", 32'(key_right), 32'd0);
    pop_chk("post_rst_74", 8'h74, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
